async_fifo_write_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO between NUM_REQ requesters in the write_clk domain.

---
 rtl/async_fifo_pkg.sv | 32 +++
 rtl/rr_priority_pick.sv | 45 ++++
 rtl/async_fifo_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_async_fifo_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// ----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared types and helpers for the async FIFO write-side logic.
//   - arb_state_t : write-port arbiter FSM states.
//   - ONEHOT_MAX  : widest one-hot vector accepted by onehot2idx.
//   - onehot2idx  : converts a one-hot (or all-zero) vector to a binary index.
// ----------------------------------------------------------------------------
package async_fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Callers zero-extend their vector to this width before conversion, so
    // designs using onehot2idx are limited to 32 requesters.
    localparam int ONEHOT_MAX = 32;

    // OR-ing the indices of all set bits gives the exact index for a one-hot
    // input and 0 for an all-zero input, with no priority chain.
    function automatic int unsigned onehot2idx(input logic [ONEHOT_MAX-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if (onehot[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage : async_fifo_pkg

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin selector. Searches req starting just above
//   last_owner and wrapping, so last_owner itself has the lowest priority.
//
//   Ports
//     req        in   NUM_REQ   request vector
//     last_owner in   IDX_W     index of the most recent owner
//     pick       out  NUM_REQ   one-hot winner (0 when no request)
//     found      out  1         at least one request present
// ----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] req_hi;

    // Requests strictly above last_owner are searched first.
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path can leave it unassigned and infer a latch.
    always_comb begin
        mask_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_hi[i] = (i > int'(last_owner));
        end
    end

    assign req_hi = req & mask_hi;

    // x & (~x + 1) isolates the lowest set bit. If nothing is above
    // last_owner, the search wraps to the lowest request overall.
    assign pick  = (|req_hi) ? (req_hi & (~req_hi + ONE))
                             : (req    & (~req    + ONE));
    assign found = |req;

endmodule : rr_priority_pick

// File: rtl/async_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// async_fifo_write_arbiter
//   Shares the single write port of the async FIFO between NUM_REQ requesters
//   in the write_clk domain. Round-robin grant with burst lock: the owner
//   keeps the port until it sends LAST, reaches MAX_BURST beats, or drops
//   valid. A write is never issued while p_write_full is high.
//
//   Parameters
//     NUM_REQ    number of requesters (2..32)
//     DATA_WIDTH FIFO word width
//     MAX_BURST  beats per grant before forced re-arbitration (>=1)
//
//   Ports
//     write_clk     in   1                   FIFO write clock
//     write_rst_n   in   1                   async active-low reset
//     p_req_valid   in   NUM_REQ             requester i has a beat
//     p_req_last    in   NUM_REQ             beat is last of requester i's burst
//     p_req_data    in   NUM_REQ*DATA_WIDTH  requester i data, slice i
//     p_req_ready   out  NUM_REQ             beat of requester i accepted
//     p_write_full  in   1                   FIFO full (registered, write domain)
//     p_write_en    out  1                   FIFO write strobe
//     p_write_data  out  DATA_WIDTH          FIFO write data
//     p_grant       out  NUM_REQ             one-hot owner, 0 when idle
//     p_busy        out  1                   FSM is in BURST
// ----------------------------------------------------------------------------
module async_fifo_write_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          write_clk,
    input  logic                          write_rst_n,
    input  logic [NUM_REQ-1:0]            p_req_valid,
    input  logic [NUM_REQ-1:0]            p_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] p_req_data,
    output logic [NUM_REQ-1:0]            p_req_ready,
    input  logic                          p_write_full,
    output logic                          p_write_en,
    output logic [DATA_WIDTH-1:0]         p_write_data,
    output logic [NUM_REQ-1:0]            p_grant,
    output logic                          p_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0] CAP_LAST       = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_OWNER_RST = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          state;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    last_owner;
    logic [CNT_W-1:0]    beat_cnt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]  pick;
    logic                found;

    rr_priority_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (p_req_valid),
        .last_owner (last_owner),
        .pick       (pick),
        .found      (found)
    );

    // ------------------------------------------------------------------
    // Owner view of the requester bus
    // ------------------------------------------------------------------
    logic                in_burst;
    logic                owner_valid;
    logic                owner_last;
    logic                accept;
    logic                cap_hit;
    logic                release_now;
    logic [IDX_W-1:0]    owner_idx;

    assign in_burst    = (state == ARB_BURST);

    // grant is one-hot while in BURST, so masking and reducing selects the
    // owner's bit without an index mux.
    assign owner_valid = |(p_req_valid & grant);
    assign owner_last  = |(p_req_last  & grant);
    assign owner_idx   = IDX_W'(onehot2idx(ONEHOT_MAX'(grant)));

    // Gating by p_write_full here is the only thing keeping writes out of a
    // full FIFO; every output strobe derives from accept.
    assign accept      = in_burst && owner_valid && !p_write_full;
    assign cap_hit     = (beat_cnt == CAP_LAST);

    // An owner that stalls on full keeps valid high, so it is not released;
    // only an owner that stops offering beats gives up the port.
    assign release_now = in_burst &&
                         (!owner_valid || (accept && (owner_last || cap_hit)));

    // ------------------------------------------------------------------
    // FIFO-side outputs: combinational from registered grant and inputs
    // ------------------------------------------------------------------
    assign p_write_en  = accept;
    assign p_req_ready = accept ? grant : '0;
    assign p_grant     = grant;
    assign p_busy      = in_burst;

    always_comb begin
        p_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                p_write_data = p_write_data | p_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered grant, owner history and beat counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= LAST_OWNER_RST;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // No beat moves this cycle: the grant is registered first.
                    if (found) begin
                        state    <= ARB_BURST;
                        grant    <= pick;
                        beat_cnt <= '0;
                    end
                end

                ARB_BURST: begin
                    if (release_now) begin
                        state      <= ARB_IDLE;
                        grant      <= '0;
                        last_owner <= owner_idx;
                        beat_cnt   <= '0;
                    end else if (accept) begin
                        // Cannot overflow: reaching CAP_LAST with accept releases.
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule : async_fifo_write_arbiter

// File: tb/tb_async_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_async_fifo_write_arbiter
//   Self-checking bench. Requester beats are queued per requester; each
//   queued beat is also pushed onto the expected FIFO-content queue, and each
//   expected grant (owner + beat count) onto a grant queue. A monitor pops
//   and compares on every FIFO write and every grant rise/fall.
// ----------------------------------------------------------------------------
module tb_async_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] grant;
        logic [31:0]        beats;
    } grant_exp_t;

    logic                          write_clk;
    logic                          write_rst_n;
    logic [NUM_REQ-1:0]            p_req_valid;
    logic [NUM_REQ-1:0]            p_req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] p_req_data;
    logic [NUM_REQ-1:0]            p_req_ready;
    logic                          p_write_full;
    logic                          p_write_en;
    logic [DATA_WIDTH-1:0]         p_write_data;
    logic [NUM_REQ-1:0]            p_grant;
    logic                          p_busy;

    async_fifo_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .p_req_valid  (p_req_valid),
        .p_req_last   (p_req_last),
        .p_req_data   (p_req_data),
        .p_req_ready  (p_req_ready),
        .p_write_full (p_write_full),
        .p_write_en   (p_write_en),
        .p_write_data (p_write_data),
        .p_grant      (p_grant),
        .p_busy       (p_busy)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    int n_checks = 0;
    int n_errors = 0;

    beat_t                 src_q [NUM_REQ][$];
    logic [DATA_WIDTH-1:0] exp_q [$];
    grant_exp_t            exp_grant [$];
    logic [DATA_WIDTH-1:0] next_data = 8'h10;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue a burst of n beats for requester r and record its expected writes.
    task automatic enqueue_burst(input int r, input int n, input bit last_at_end);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data    = next_data;
            b.last    = last_at_end && (k == n - 1);
            next_data = next_data + 8'd1;
            src_q[r].push_back(b);
            exp_q.push_back(b.data);
        end
    endtask

    task automatic expect_grant(input logic [NUM_REQ-1:0] g, input int beats);
        grant_exp_t e;
        e.grant = g;
        e.beats = 32'(beats);
        exp_grant.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_grant.size() != 0) && n < budget) begin
            @(posedge write_clk);
            n++;
        end
        #3;
        check("drain_writes", 32'(exp_q.size()), 32'd0);
        check("drain_grants", 32'(exp_grant.size()), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            check("src_empty", 32'(src_q[i].size()), 32'd0);
        end
    endtask

    task automatic wait_grant(input logic [NUM_REQ-1:0] g, input int budget);
        int n;
        n = 0;
        while (p_grant !== g && n < budget) begin
            @(posedge write_clk);
            #3;
            n++;
        end
        check("wait_grant", 32'(p_grant), 32'(g));
    endtask

    // Requester driver: valid/data/last follow the head of each queue; a
    // beat seen ready before an edge is retired just after that edge.
    initial begin
        logic [NUM_REQ-1:0] ready_s;
        p_req_valid = '0;
        p_req_last  = '0;
        p_req_data  = '0;
        forever begin
            @(negedge write_clk);
            ready_s = p_req_ready;
            @(posedge write_clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ready_s[i] === 1'b1 && src_q[i].size() != 0) begin
                    void'(src_q[i].pop_front());
                end
                if (src_q[i].size() != 0) begin
                    p_req_valid[i] = 1'b1;
                    p_req_last[i]  = src_q[i][0].last;
                    p_req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0].data;
                end else begin
                    p_req_valid[i] = 1'b0;
                    p_req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: invariants every cycle, FIFO contents and grant sequence.
    initial begin
        logic [NUM_REQ-1:0] prev_grant;
        int                 beats;
        grant_exp_t         e;
        prev_grant = '0;
        beats      = 0;
        forever begin
            @(negedge write_clk);
            if (write_rst_n !== 1'b1) begin
                check("rst_grant", 32'(p_grant), 32'd0);
                check("rst_write_en", 32'(p_write_en), 32'd0);
                check("rst_busy", 32'(p_busy), 32'd0);
                check("rst_ready", 32'(p_req_ready), 32'd0);
                prev_grant = '0;
                beats      = 0;
            end else begin
                check("en_while_full", 32'(p_write_en & p_write_full), 32'd0);
                check("grant_onehot0", 32'($onehot0(p_grant)), 32'd1);
                check("en_vs_ready", 32'(p_write_en), 32'(|p_req_ready));
                check("busy_vs_grant", 32'(p_busy), 32'(|p_grant));
                if (p_grant !== prev_grant) begin
                    check("idle_gap", 32'(prev_grant != '0 && p_grant != '0), 32'd0);
                    if (prev_grant != '0) begin
                        if (exp_grant.size() == 0) begin
                            check("grant_release_unexp", 32'(prev_grant), 32'd0);
                        end else begin
                            e = exp_grant.pop_front();
                            check("burst_beats", 32'(beats), e.beats);
                        end
                    end
                    if (p_grant != '0) begin
                        if (exp_grant.size() == 0) begin
                            check("grant_unexp", 32'(p_grant), 32'd0);
                        end else begin
                            check("grant_owner", 32'(p_grant), 32'(exp_grant[0].grant));
                        end
                    end
                    beats = 0;
                end
                if (p_write_en === 1'b1) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("write_unexp", 32'(p_write_data), 32'hffff_ffff);
                    end else begin
                        check("write_data", 32'(p_write_data), 32'(exp_q.pop_front()));
                    end
                end
                prev_grant = p_grant;
            end
        end
    end

    initial begin
        write_rst_n  = 1'b0;
        p_write_full = 1'b0;

        // Reset with all requesters valid; then round-robin with single-beat
        // bursts: grants 0,1,2,3,0.
        @(posedge write_clk); #3;
        enqueue_burst(0, 1, 1'b1);
        enqueue_burst(1, 1, 1'b1);
        enqueue_burst(2, 1, 1'b1);
        enqueue_burst(3, 1, 1'b1);
        enqueue_burst(0, 1, 1'b1);
        expect_grant(4'b0001, 1);
        expect_grant(4'b0010, 1);
        expect_grant(4'b0100, 1);
        expect_grant(4'b1000, 1);
        expect_grant(4'b0001, 1);
        repeat (4) @(posedge write_clk);
        #3;
        check("rst_valid_held", 32'(p_req_valid), 32'hf);
        write_rst_n = 1'b1;
        drain(200);

        // Burst cap: 20 beats without LAST -> 16, bubble, re-grant for 4.
        @(posedge write_clk); #3;
        enqueue_burst(2, 20, 1'b0);
        expect_grant(4'b0100, MAX_BURST);
        expect_grant(4'b0100, 20 - MAX_BURST);
        drain(200);

        // Full stall mid-burst for 5 cycles.
        @(posedge write_clk); #3;
        enqueue_burst(0, 8, 1'b1);
        expect_grant(4'b0001, 8);
        wait_grant(4'b0001, 20);
        repeat (3) @(posedge write_clk);
        #3;
        p_write_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge write_clk);
            check("stall_write_en", 32'(p_write_en), 32'd0);
            check("stall_ready", 32'(p_req_ready), 32'd0);
            check("stall_grant", 32'(p_grant), 32'h1);
            @(posedge write_clk); #3;
        end
        p_write_full = 1'b0;
        drain(200);

        // Owner drop: req1 sends 3 beats then drops valid; req3 is next.
        @(posedge write_clk); #3;
        enqueue_burst(1, 3, 1'b0);
        enqueue_burst(3, 2, 1'b1);
        expect_grant(4'b0010, 3);
        expect_grant(4'b1000, 2);
        drain(200);

        repeat (3) @(posedge write_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_async_fifo_write_arbiter
